// File: rtl/mc_core_seq.sv
// Multi-cycle instruction sequencer for the core.
// Owns the PC and instruction register and walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB. Instruction and data memories use ready/valid
// handshakes and may stall for any number of cycles. HALT and TRAP are
// terminal states that only reset can leave. All request and strobe outputs
// are Moore decodes of the state register, so an asserted reset drops them
// in the same cycle.
module mc_core_seq #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     CNT_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [PC_W-1:0]  pc,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             is_illegal,
  input  logic             rf_we_in,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             halted,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    TRAP   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] cycle_q, instret_q, instret_d;
  logic             retire;
  logic             misaligned;
  logic             active;
  logic             fetch_done;

  // A redirect to a non-word-aligned target cannot be fetched, so it traps.
  assign misaligned = br_taken && (br_target[1:0] != 2'b00);

  // Cycles are only counted while an instruction is actually in flight.
  assign active = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC) ||
                  (state_q == MEM)   || (state_q == WB);

  assign fetch_done = (state_q == FETCH) && imem_ready;

  // Next-state, next-PC and retire logic; retire happens on the edge that leaves WB, or MEM for stores.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    retire    = 1'b0;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (imem_ready) state_d = DECODE;
      DECODE: begin
        if (is_illegal)   state_d = TRAP;
        else if (is_halt) state_d = HALT;
        else              state_d = EXEC;
      end
      EXEC:   state_d = (is_load || is_store) ? MEM : WB;
      MEM: begin
        if (dmem_ready) begin
          if (is_store) retire  = 1'b1;
          else          state_d = WB;
        end
      end
      WB:     retire = 1'b1;
      HALT:   state_d = HALT;
      TRAP:   state_d = TRAP;
      default: state_d = state_q;
    endcase
    if (retire) begin
      if (misaligned) begin
        state_d = TRAP;
      end else begin
        state_d   = FETCH;
        pc_d      = br_taken ? br_target : (pc_q + PC_W'(4));
        instret_d = instret_q + CNT_W'(1);
      end
    end
  end

  // State register, PC and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  // Instruction register captures the fetched word on the completing fetch edge only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
    end else if (fetch_done) begin
      instr_q <= imem_rdata;
    end
  end

  // Free-running cycle counter that pauses in IDLE, HALT and TRAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else if (active) begin
      cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign dmem_req    = (state_q == MEM);
  assign dmem_we     = (state_q == MEM) && is_store;
  assign rf_we       = (state_q == WB) && rf_we_in;
  assign halted      = (state_q == HALT);
  assign trap        = (state_q == TRAP);
  assign state       = state_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mc_core_seq.sv
// Directed bench for mc_core_seq using a narrow 8-bit PC so address wrap
// is reachable. Each instruction pushes its expected retire outcome into a
// scoreboard queue when its stimulus is issued; the entry is popped and
// compared once the sequencer leaves the instruction.
module tb_mc_core_seq;

  localparam int unsigned     PC_W     = 8;
  localparam int unsigned     CNT_W    = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] LW    = 32'h0000_A103;
  localparam logic [31:0] SW    = 32'h0020_A023;
  localparam logic [31:0] JAL   = 32'h0000_006F;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] BAD   = 32'hFFFF_FFFF;

  logic             clk;
  logic             reset;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic [PC_W-1:0]  pc;
  logic             is_load, is_store, is_halt, is_illegal, rf_we_in;
  logic             br_taken;
  logic [PC_W-1:0]  br_target;
  logic             dmem_req, dmem_we, dmem_ready;
  logic             rf_we, halted, trap;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  typedef struct {
    logic [PC_W-1:0]  next_pc;
    logic [CNT_W-1:0] instret;
    logic [CNT_W-1:0] cycles;
    logic [2:0]       state;
  } exp_t;

  exp_t             sb_q[$];
  int               compared;
  int               mismatched;
  logic [PC_W-1:0]  model_pc;
  logic [CNT_W-1:0] model_instret;
  logic [CNT_W-1:0] model_cycle;
  logic [31:0]      model_instr;

  mc_core_seq #(
    .PC_W(PC_W),
    .CNT_W(CNT_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .pc(pc),
    .is_load(is_load),
    .is_store(is_store),
    .is_halt(is_halt),
    .is_illegal(is_illegal),
    .rf_we_in(rf_we_in),
    .br_taken(br_taken),
    .br_target(br_target),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_ready(dmem_ready),
    .rf_we(rf_we),
    .halted(halted),
    .trap(trap),
    .state(state),
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decode();
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    rf_we_in   = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_state"},   32'(state), 32'd0);
    check_output({tag, "_pc"},      32'(pc), 32'(RESET_PC));
    check_output({tag, "_instr"},   instr, 32'd0);
    check_output({tag, "_imemreq"}, 32'(imem_req), 32'd0);
    check_output({tag, "_dmemreq"}, 32'(dmem_req), 32'd0);
    check_output({tag, "_rfwe"},    32'(rf_we), 32'd0);
    check_output({tag, "_flags"},   32'({halted, trap}), 32'd0);
    check_output({tag, "_cycle"},   cycle_cnt, 32'd0);
    check_output({tag, "_instret"}, instret_cnt, 32'd0);
  endtask

  // Hold reset, check reset values, release, and watch the single IDLE cycle.
  task automatic reset_dut();
    reset      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    clear_decode();
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b1;
    check_output("idle_state", 32'(state), 32'd0);
    tick();
    check_output("idle_to_fetch", 32'(state), 32'd1);
    check_output("fetch_addr0", 32'(imem_addr), 32'(RESET_PC));
    check_output("cycle_after_idle", cycle_cnt, 32'd0);
    model_pc      = RESET_PC;
    model_instret = '0;
    model_cycle   = '0;
    model_instr   = '0;
  endtask

  // Fetch with iwait stall cycles; returns in DECODE with the word latched.
  task automatic fetch_word(input logic [31:0] word, input int iwait);
    for (int i = 0; i < iwait; i++) begin
      check_output("fetch_wait_req", 32'(imem_req), 32'd1);
      check_output("fetch_wait_addr", 32'(imem_addr), 32'(model_pc));
      check_output("fetch_wait_instr", instr, model_instr);
      imem_rdata = ~word;
      tick();
    end
    check_output("fetch_req", 32'(imem_req), 32'd1);
    check_output("fetch_addr", 32'(imem_addr), 32'(model_pc));
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    model_instr = word;
    check_output("decode_state", 32'(state), 32'd2);
    check_output("decode_instr", instr, word);
    check_output("decode_imemreq", 32'(imem_req), 32'd0);
  endtask

  // Run one retiring (or branch-trapping) instruction from FETCH.
  task automatic run_instr(input logic [31:0] word, input int iwait, input bit ld, input bit st,
                           input int dwait, input bit we_in, input bit taken,
                           input logic [PC_W-1:0] target);
    exp_t e;
    bit   mis;
    int   lat;
    mis = taken && (target[1:0] != 2'b00);
    lat = 4 + iwait + (ld ? 1 : 0) + ((ld || st) ? dwait : 0);
    e.next_pc = mis ? model_pc : (taken ? target : model_pc + PC_W'(4));
    e.instret = mis ? model_instret : model_instret + CNT_W'(1);
    e.cycles  = model_cycle + CNT_W'(lat);
    e.state   = mis ? 3'd7 : 3'd1;
    sb_q.push_back(e);

    fetch_word(word, iwait);
    is_load   = ld;
    is_store  = st;
    rf_we_in  = we_in;
    br_taken  = taken;
    br_target = target;
    check_output("decode_rfwe", 32'(rf_we), 32'd0);
    tick();
    check_output("exec_state", 32'(state), 32'd3);
    tick();
    if (ld || st) begin
      check_output("mem_state", 32'(state), 32'd4);
      check_output("mem_we", 32'(dmem_we), 32'(st));
      check_output("mem_rfwe", 32'(rf_we), 32'd0);
      for (int i = 0; i < dwait; i++) begin
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check_output("mem_wait_req", 32'(dmem_req), 32'd1);
      end
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
    end
    if (!st) begin
      check_output("wb_state", 32'(state), 32'd5);
      check_output("wb_rfwe", 32'(rf_we), 32'(we_in));
      check_output("wb_dmemreq", 32'(dmem_req), 32'd0);
      tick();
    end
    clear_decode();

    check_output("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_output("retire_state", 32'(state), 32'(e.state));
      check_output("retire_pc", 32'(pc), 32'(e.next_pc));
      check_output("retire_instret", instret_cnt, e.instret);
      check_output("retire_cycle", cycle_cnt, e.cycles);
      model_pc      = e.next_pc;
      model_instret = e.instret;
      model_cycle   = e.cycles;
    end
  endtask

  // Fetch and decode an ECALL or illegal word, ending in HALT or TRAP.
  task automatic run_terminal(input logic [31:0] word, input bit halt_i, input bit illegal_i);
    fetch_word(word, 0);
    is_halt    = halt_i;
    is_illegal = illegal_i;
    tick();
    clear_decode();
    model_cycle = model_cycle + CNT_W'(2);
    check_output("term_state", 32'(state), illegal_i ? 32'd7 : 32'd6);
    check_output("term_halted", 32'(halted), 32'(halt_i && !illegal_i));
    check_output("term_trap", 32'(trap), 32'(illegal_i));
  endtask

  // Terminal state must issue nothing and freeze pc and counters.
  task automatic check_frozen(input int n, input logic [2:0] exp_state);
    for (int i = 0; i < n; i++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      tick();
      check_output("frozen_reqs", 32'({imem_req, dmem_req, rf_we}), 32'd0);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check_output("frozen_state", 32'(state), 32'(exp_state));
    check_output("frozen_pc", 32'(pc), 32'(model_pc));
    check_output("frozen_cycle", cycle_cnt, model_cycle);
    check_output("frozen_instret", instret_cnt, model_instret);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    $display("[TB] ALU stream from reset");
    reset_dut();
    run_instr(ADDI, 0, 0, 0, 0, 1, 0, '0);
    run_instr(ADDI, 0, 0, 0, 0, 1, 0, '0);
    run_instr(ADDI, 0, 0, 0, 0, 1, 0, '0);
    check_output("three_instret", instret_cnt, 32'd3);
    check_output("three_cycles", cycle_cnt, 32'd12);

    $display("[TB] fetch stall, load, store");
    run_instr(ADDI, 3, 0, 0, 0, 1, 0, '0);
    check_output("stall_cycles", cycle_cnt, 32'd19);
    run_instr(LW, 0, 1, 0, 2, 1, 0, '0);
    check_output("load_cycles", cycle_cnt, 32'd26);
    run_instr(SW, 0, 0, 1, 0, 0, 0, '0);
    check_output("store_cycles", cycle_cnt, 32'd30);
    check_output("ldst_instret", instret_cnt, 32'd6);

    $display("[TB] branch redirect and pc wrap");
    run_instr(JAL, 0, 0, 0, 0, 0, 1, 8'hF8);
    run_instr(ADDI, 0, 0, 0, 0, 1, 0, '0);
    check_output("pc_fc", 32'(pc), 32'hFC);
    run_instr(ADDI, 0, 0, 0, 0, 1, 0, '0);
    check_output("pc_wrap", 32'(pc), 32'h00);
    run_instr(JAL, 0, 0, 0, 0, 0, 1, 8'h40);
    check_output("pc_branch", 32'(pc), 32'h40);
    run_instr(JAL, 0, 0, 0, 0, 0, 1, 8'h42);
    check_output("misalign_trap", 32'(trap), 32'd1);
    check_frozen(5, 3'd7);

    $display("[TB] halt at 0x10");
    reset_dut();
    for (int i = 0; i < 4; i++) run_instr(ADDI, 0, 0, 0, 0, 1, 0, '0);
    check_output("halt_pc", 32'(pc), 32'h10);
    run_terminal(ECALL, 1, 0);
    check_frozen(20, 3'd6);

    $display("[TB] illegal instruction");
    reset_dut();
    run_terminal(BAD, 1, 1);
    check_frozen(3, 3'd7);

    $display("[TB] reset mid-MEM");
    reset_dut();
    fetch_word(LW, 0);
    is_load = 1'b1;
    tick();
    tick();
    check_output("midmem_req", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midmem");
    clear_decode();
    dmem_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_output("restart_state", 32'(state), 32'd1);
    check_output("restart_req", 32'(imem_req), 32'd1);
    check_output("restart_addr", 32'(imem_addr), 32'(RESET_PC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
